pid_axis_controller: RTL and testbench
======================================

Name: pid_axis_controller

Overview:
- Closed-loop per-axis PID controller: the consumer of the plant's `angle` and the producer of its `control` input.
- On each `tick` it samples `setpoint` and `angle`, then computes P, I and D terms on one shared multiplier over a fixed multi-cycle schedule.
- It publishes a saturated 16-bit `control` with a one-cycle `valid` strobe.
- One instance per axis, ticked by the same loop strobe as the plant.

Parameters:
- KP, 4, signed 16-bit proportional gain.
- KI, 1, signed 16-bit integral gain.
- KD, 2, signed 16-bit derivative gain.
- SHIFT, 2, arithmetic right shift applied to the gain sum (fixed-point scale).
- I_LIM, 1000, positive integrator clamp magnitude, must be < 2^23.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  control-loop strobe, single-cycle pulse.
- setpoint  input  16 signed  commanded angle.
- angle  input  16 signed  measured angle from plant.
- clear  input  1  synchronous clear of integrator and previous error.
- control  output  16 signed  actuator command to plant.
- valid  output  1  one-cycle pulse when control updates.
- busy  output  1  high while a computation is in flight.
- overrun  output  1  sticky: tick arrived while busy.

Behaviour:
- Reset (rst_n low, asynchronous): control=0, valid=0, busy=0, overrun=0, integ=0, e_prev=0, FSM=IDLE. Reset mid-computation aborts it; no valid is issued.
- FSM states and timing (tick accepted at edge N):
  - IDLE: on tick, capture setpoint/angle at edge N → ERR.
  - ERR (edge N+1):
    - e = sp - ang, 17-bit signed.
    - integ = clamp(integ + e, -I_LIM, +I_LIM), 24-bit signed.
    - d = e - e_prev, 18-bit signed.
    - e_prev <= e.
    - → MP.
  - MP (edge N+2): acc = KP*e, 40-bit signed → MI.
  - MI (edge N+3): acc += KI*integ → MD.
  - MD (edge N+4): acc += KD*d → OUT.
  - OUT (edge N+5): control <= sat16(acc >>> SHIFT); valid=1 for exactly the cycle following edge N+5 → IDLE.
- Latency: control visible 5 cycles after the tick edge. A new tick is accepted in the cycle valid is high, since the FSM is in IDLE.
- busy: high from edge N through the edge that asserts valid; low in IDLE.
- Tick while busy: ignored, with no effect on sampling or state. overrun <= 1 (sticky; only rst_n clears it).
- Arithmetic rules:
  - Shift is arithmetic, so rounding is toward negative infinity.
  - sat16 clamps to [-32768, 32767].
  - Products are full precision with no intermediate truncation.
- clear:
  - In IDLE: integ=0 and e_prev=0 next edge.
  - With tick in the same cycle: clear applies first, then the tick is accepted and ERR uses integ=0, e_prev=0.
  - While busy: ignored.
- control holds its last value between updates.

Test Plan:
1. After reset, setpoint=100, angle=0, one tick → after 5 cycles control=175 (400+100+200=700>>>2), valid pulses once, busy high for cycles N..N+5.
2. Second tick, same inputs → control=150 (e=100, integ=200, d=0: 600>>>2).
3. Windup: setpoint=100, angle=0, 15 ticks → integ clamped at 1000. Final control=(400+1000+0)>>>2=350.
4. Saturation: fresh reset, setpoint=32767, angle=-32768, tick → sum 394210>>>2=98552 → control=32767. Repeat with signs swapped → control=-32768.
5. Floor rounding: fresh reset, setpoint=0, angle=1, tick → sum -7 → control=-2. Then clear pulse, then tick at setpoint=angle=0 → control=0.
6. Tick at N and N+2 → one valid only, overrun=1 stays set. rst_n low at N+3 of a new computation → control=0, valid never pulses, overrun=0, busy=0.

Source files
------------

// File: rtl/pid_axis_controller.sv
// -----------------------------------------------------------------------------
// pid_axis_controller
//
// Per-axis PID controller. Each tick samples setpoint and angle, then evaluates
// the P, I and D terms on a single shared multiplier over a fixed schedule:
//   IDLE -> ERR -> MP -> MI -> MD -> OUT -> IDLE
// The result is published on control (saturated to 16 bits), along with a
// one-cycle valid strobe five cycles after the accepted tick.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   tick      in   control-loop strobe (single-cycle pulse)
//   setpoint  in   signed 16-bit commanded angle
//   angle     in   signed 16-bit measured angle
//   clear     in   synchronous clear of integrator and previous error (IDLE only)
//   control   out  signed 16-bit actuator command, held between updates
//   valid     out  one-cycle pulse when control updates
//   busy      out  high while a computation is in flight
//   overrun   out  sticky flag: tick arrived while busy
// -----------------------------------------------------------------------------
module pid_axis_controller #(
   parameter logic signed [15:0] KP    = 16'sd4,
   parameter logic signed [15:0] KI    = 16'sd1,
   parameter logic signed [15:0] KD    = 16'sd2,
   parameter int                 SHIFT = 2,
   parameter int                 I_LIM = 1000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic signed [15:0] setpoint,
   input  logic signed [15:0] angle,
   input  logic               clear,
   output logic signed [15:0] control,
   output logic               valid,
   output logic               busy,
   output logic               overrun
);

   localparam logic signed [24:0] I_MAX = 25'(I_LIM);
   localparam logic signed [24:0] I_MIN = -I_MAX;

   typedef enum logic [2:0] {IDLE, ERR, MP, MI, MD, OUT} state_t;

   state_t state, state_nxt;

   logic signed [15:0] sp_p0, ang_p0;
   logic signed [16:0] e_p1, e_prev;
   logic signed [17:0] d_p1;
   logic signed [23:0] integ;
   logic signed [39:0] acc_p2;

   logic signed [16:0] e_new;
   logic signed [17:0] d_new;
   logic signed [24:0] integ_sum;
   logic signed [15:0] mul_a;
   logic signed [23:0] mul_b;
   logic signed [39:0] prod;

   // Integrator clamp to [-I_LIM, +I_LIM]; the 25-bit sum cannot wrap.
   function automatic logic signed [23:0] clamp_integ(input logic signed [24:0] v);
      if (v > I_MAX)
         return I_MAX[23:0];
      else if (v < I_MIN)
         return I_MIN[23:0];
      else
         return v[23:0];
   endfunction

   // Saturate the scaled accumulator into the 16-bit actuator range.
   function automatic logic signed [15:0] sat16(input logic signed [39:0] v);
      if (v > 40'sd32767)
         return 16'sh7fff;
      else if (v < -40'sd32768)
         return 16'sh8000;
      else
         return v[15:0];
   endfunction

   assign busy = (state != IDLE);

   // Error terms, all widened so no intermediate value can wrap.
   assign e_new     = {sp_p0[15], sp_p0} - {ang_p0[15], ang_p0};
   assign d_new     = {e_new[16], e_new} - {e_prev[16], e_prev};
   assign integ_sum = {integ[23], integ} + {{8{e_new[16]}}, e_new};

   // Shared multiplier: gain/operand pair selected by schedule step.
   always_comb begin
      mul_a = KP;
      mul_b = {{7{e_p1[16]}}, e_p1};
      case (state)
         MI: begin
            mul_a = KI;
            mul_b = integ;
         end
         MD: begin
            mul_a = KD;
            mul_b = {{6{d_p1[17]}}, d_p1};
         end
         default: ;
      endcase
   end

   assign prod = 40'(mul_a) * 40'(mul_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (tick) state_nxt = ERR;
         ERR:     state_nxt = MP;
         MP:      state_nxt = MI;
         MI:      state_nxt = MD;
         MD:      state_nxt = OUT;
         OUT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p0: input capture; p1: error and derivative; p2: accumulation.
   always_ff @(posedge clk) begin
      if (state == IDLE && tick) begin
         sp_p0  <= setpoint;
         ang_p0 <= angle;
      end
      if (state == ERR) begin
         e_p1 <= e_new;
         d_p1 <= d_new;
      end
      case (state)
         MP:      acc_p2 <= prod;
         MI, MD:  acc_p2 <= acc_p2 + prod;
         default: ;
      endcase
   end

   // Loop state and outputs; clear only takes effect while idle, and a tick
   // in the same cycle then sees the zeroed history in ERR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         integ   <= '0;
         e_prev  <= '0;
         control <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         valid <= (state == OUT);
         if (state == IDLE && clear) begin
            integ  <= '0;
            e_prev <= '0;
         end else if (state == ERR) begin
            integ  <= clamp_integ(integ_sum);
            e_prev <= e_new;
         end
         if (state == OUT)
            control <= sat16(acc_p2 >>> SHIFT);
         if (tick && state != IDLE)
            overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pid_axis_controller.sv
module tb_pid_axis_controller;

   logic               clk;
   logic               rst_n;
   logic               tick;
   logic signed [15:0] setpoint;
   logic signed [15:0] angle;
   logic               clear;
   logic signed [15:0] control;
   logic               valid;
   logic               busy;
   logic               overrun;

   int n_assert = 0;
   int n_fail   = 0;

   pid_axis_controller dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .setpoint (setpoint),
      .angle    (angle),
      .clear    (clear),
      .control  (control),
      .valid    (valid),
      .busy     (busy),
      .overrun  (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected end before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      tick  = 1'b0;
      clear = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One tick, then wait (bounded) for valid. lat = negedges after the tick
   // edge at which valid was first seen, -1 if never.
   task automatic do_tick(input logic signed [15:0] sp, input logic signed [15:0] ang,
                          input logic clr, input logic clr_mid,
                          output int lat, output logic signed [15:0] ctl,
                          output logic busy0, output logic busyv);
      @(negedge clk);
      setpoint = sp;
      angle    = ang;
      tick     = 1'b1;
      clear    = clr;
      @(negedge clk);
      tick  = 1'b0;
      clear = 1'b0;
      busy0 = busy;
      busyv = 1'b1;
      lat   = -1;
      for (int i = 1; i <= 10; i++) begin
         clear = (clr_mid && i == 2);
         @(negedge clk);
         if (valid) begin
            lat   = i;
            busyv = busy;
            break;
         end
      end
      clear = 1'b0;
      ctl   = control;
   endtask

   initial begin
      int                 lat;
      int                 nvalid;
      logic signed [15:0] ctl;
      logic signed [15:0] seen;
      logic               b0, bv;

      rst_n    = 1'b0;
      tick     = 1'b0;
      clear    = 1'b0;
      setpoint = '0;
      angle    = '0;
      @(negedge clk);
      @(negedge clk);
      check("reset_control", control, 0);
      check("reset_valid",   valid,   0);
      check("reset_busy",    busy,    0);
      check("reset_overrun", overrun, 0);
      rst_n = 1'b1;

      // First tick: 400 + 100 + 200 = 700 >>> 2
      do_tick(16'sd100, 16'sd0, 1'b0, 1'b0, lat, ctl, b0, bv);
      check("t1_latency",     lat, 5);
      check("t1_control",     ctl, 175);
      check("t1_busy_after",  b0,  1);
      check("t1_busy_valid",  bv,  0);
      @(negedge clk);
      check("t1_valid_single", valid, 0);
      check("t1_control_hold", control, 175);

      // Second tick: integ=200, d=0 -> 600 >>> 2
      do_tick(16'sd100, 16'sd0, 1'b0, 1'b0, lat, ctl, b0, bv);
      check("t2_latency", lat, 5);
      check("t2_control", ctl, 150);

      // Windup: 15 ticks, integrator pinned at 1000
      for (int k = 0; k < 14; k++)
         do_tick(16'sd100, 16'sd0, 1'b0, 1'b0, lat, ctl, b0, bv);
      do_tick(16'sd100, 16'sd0, 1'b0, 1'b0, lat, ctl, b0, bv);
      check("windup_control", ctl, 350);

      // Clear with tick in the same cycle: behaves like a fresh loop
      do_tick(16'sd100, 16'sd0, 1'b1, 1'b0, lat, ctl, b0, bv);
      check("clear_tick_control", ctl, 175);

      // Clear while busy is ignored: e=40, integ=140, d=-60 -> 180 >>> 2
      do_tick(16'sd40, 16'sd0, 1'b0, 1'b1, lat, ctl, b0, bv);
      check("clear_busy_control", ctl, 45);
      // History kept: e=0, integ=140, d=-40 -> 60 >>> 2
      do_tick(16'sd0, 16'sd0, 1'b0, 1'b0, lat, ctl, b0, bv);
      check("clear_busy_history", ctl, 15);

      // Saturation both directions
      do_reset();
      do_tick(16'sd32767, -16'sd32768, 1'b0, 1'b0, lat, ctl, b0, bv);
      check("sat_pos", ctl, 32767);
      do_tick(-16'sd32768, 16'sd32767, 1'b0, 1'b0, lat, ctl, b0, bv);
      check("sat_neg", ctl, -32768);

      // Floor rounding: -7 >>> 2 = -2
      do_reset();
      do_tick(16'sd0, 16'sd1, 1'b0, 1'b0, lat, ctl, b0, bv);
      check("floor_control", ctl, -2);
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      do_tick(16'sd0, 16'sd0, 1'b0, 1'b0, lat, ctl, b0, bv);
      check("after_clear_zero", ctl, 0);
      // Cleared history: e=4, integ=4, d=4 -> 28 >>> 2
      do_tick(16'sd4, 16'sd0, 1'b0, 1'b0, lat, ctl, b0, bv);
      check("after_clear_next", ctl, 7);

      // Overrun: second tick two cycles later is ignored
      do_reset();
      check("ovr_initial", overrun, 0);
      @(negedge clk);
      setpoint = 16'sd100;
      angle    = 16'sd0;
      tick     = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      setpoint = 16'sd500;
      tick     = 1'b1;
      @(negedge clk);
      tick   = 1'b0;
      nvalid = 0;
      seen   = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (valid) begin
            nvalid++;
            seen = control;
         end
      end
      check("ovr_valid_count", nvalid, 1);
      check("ovr_control",     seen,   175);
      check("ovr_sticky",      overrun, 1);
      do_tick(16'sd100, 16'sd0, 1'b0, 1'b0, lat, ctl, b0, bv);
      check("ovr_next_control", ctl, 150);
      check("ovr_still_set",    overrun, 1);

      // Reset mid-computation aborts it
      @(negedge clk);
      setpoint = 16'sd100;
      tick     = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_control", control, 0);
      check("abort_busy",    busy,    0);
      check("abort_overrun", overrun, 0);
      check("abort_valid",   valid,   0);
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      nvalid = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (valid) nvalid++;
      end
      check("abort_no_valid",  nvalid, 0);
      check("abort_idle_busy", busy,   0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
